// File: rtl/cfdf_fire_scheduler_if.sv
// Link between the fire scheduler and the nested firing FSM: start/mode
// going down, decoded instruction, argument and completion coming back up.
interface cfdf_fire_scheduler_if;
    logic       start_fsm2;
    logic [1:0] next_instr;
    logic [7:0] instr;
    logic [4:0] arg2;
    logic       done_fsm2;

    modport master (
        output start_fsm2,
        output next_instr,
        input  instr,
        input  arg2,
        input  done_fsm2
    );

    modport slave (
        input  start_fsm2,
        input  next_instr,
        output instr,
        output arg2,
        output done_fsm2
    );
endinterface

// File: rtl/cfdf_fire_scheduler.sv
// CFDF fire scheduler: checks FIFO populations against the token rates of the
// decoded instruction, launches SETUP_INSTR / INSTR firings of the nested FSM
// and guards every wait for completion with a watchdog.
module cfdf_fire_scheduler #(
    parameter int buffer_size = 1024,
    parameter int out_size    = 1024,
    parameter int timeout     = 4096,
    parameter int rst_wait    = 2,
    localparam int AW = $clog2(buffer_size),
    localparam int OW = $clog2(out_size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic [AW-1:0]         pop_in_fifo_data_i,
    input  logic [AW-1:0]         pop_in_fifo_command_i,
    input  logic [OW-1:0]         free_out_fifo_i,
    cfdf_fire_scheduler_if.master fsm2,
    output logic                  busy_o,
    output logic                  err_timeout_o,
    output logic                  err_illegal_o,
    output logic [15:0]           fire_count_o
);

    localparam int WW = $clog2(timeout) + 1;

    typedef logic [AW:0] dataRate_t;
    typedef logic [OW:0] outRate_t;

    typedef enum logic [3:0] {
        IDLE,
        CHECK_CMD,
        START_SETUP,
        WAIT_SETUP,
        CHECK_INSTR,
        START_INSTR,
        WAIT_INSTR,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          start_q, start_d;
    logic [1:0]    nextInstr_q, nextInstr_d;
    logic          busy_q, busy_d;
    logic          errTimeout_q, errTimeout_d;
    logic          errIllegal_q, errIllegal_d;
    logic [15:0]   fireCount_q, fireCount_d;

    dataRate_t     needData;
    outRate_t      needOut;
    logic          illegal;
    logic          isRst;
    logic          ratesOk;
    logic          wdExpired;
    logic          instrComplete;

    // Token demand of the current instruction, one bit wider than the FIFO counts
    always_comb begin
        needData = '0;
        needOut  = '0;
        case (fsm2.instr)
            8'd0: begin
                needData = dataRate_t'(fsm2.arg2) + dataRate_t'(1);
                needOut  = outRate_t'(1);
            end
            8'd1: begin
                needData = dataRate_t'(1);
                needOut  = outRate_t'(1);
            end
            8'd2: begin
                needData = dataRate_t'(fsm2.arg2);
                needOut  = outRate_t'(fsm2.arg2);
            end
            default: begin
                needData = '0;
                needOut  = '0;
            end
        endcase
    end

    assign illegal       = (fsm2.instr > 8'd3);
    assign isRst         = (fsm2.instr == 8'd3);
    assign ratesOk       = ({1'b0, pop_in_fifo_data_i} >= needData) &&
                           ({1'b0, free_out_fifo_i} >= needOut);
    assign wdExpired     = (wd_q == WW'(timeout - 1));
    assign instrComplete = isRst ? (wd_q == WW'(rst_wait - 1)) : fsm2.done_fsm2;

    // State register; reset pulls everything back to IDLE from any state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: completion always takes priority over watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (run_i) state_d = CHECK_CMD;
            CHECK_CMD: begin
                if (pop_in_fifo_command_i != '0) state_d = START_SETUP;
                else if (!run_i)                 state_d = IDLE;
            end
            START_SETUP: state_d = WAIT_SETUP;
            WAIT_SETUP: begin
                if (fsm2.done_fsm2) state_d = CHECK_INSTR;
                else if (wdExpired) state_d = ERR;
            end
            CHECK_INSTR: begin
                if (illegal)      state_d = CHECK_CMD;
                else if (ratesOk) state_d = START_INSTR;
            end
            START_INSTR: state_d = WAIT_INSTR;
            WAIT_INSTR: begin
                if (instrComplete)  state_d = run_i ? CHECK_CMD : IDLE;
                else if (wdExpired) state_d = ERR;
            end
            ERR:         state_d = ERR;
            default:     state_d = IDLE;
        endcase
    end

    // Output/datapath next values, derived from the upcoming state so outputs are registered Moore
    always_comb begin
        start_d      = (state_d == START_SETUP) || (state_d == START_INSTR);
        nextInstr_d  = nextInstr_q;
        busy_d       = (state_d != IDLE);
        errTimeout_d = errTimeout_q;
        errIllegal_d = errIllegal_q;
        fireCount_d  = fireCount_q;
        wd_d         = '0;
        if (state_d == START_SETUP) nextInstr_d = 2'b00;
        if (state_d == START_INSTR) nextInstr_d = 2'b01;
        if ((state_d == ERR) && (state_q != ERR)) errTimeout_d = 1'b1;
        if ((state_q == CHECK_INSTR) && illegal) errIllegal_d = 1'b1;
        if ((state_q == WAIT_INSTR) && instrComplete) fireCount_d = fireCount_q + 16'd1;
        if (((state_d == WAIT_SETUP) || (state_d == WAIT_INSTR)) && (state_d == state_q)) begin
            wd_d = wd_q + WW'(1);
        end
    end

    // Output and watchdog registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q         <= '0;
            start_q      <= 1'b0;
            nextInstr_q  <= 2'b00;
            busy_q       <= 1'b0;
            errTimeout_q <= 1'b0;
            errIllegal_q <= 1'b0;
            fireCount_q  <= 16'd0;
        end else begin
            wd_q         <= wd_d;
            start_q      <= start_d;
            nextInstr_q  <= nextInstr_d;
            busy_q       <= busy_d;
            errTimeout_q <= errTimeout_d;
            errIllegal_q <= errIllegal_d;
            fireCount_q  <= fireCount_d;
        end
    end

    assign fsm2.start_fsm2 = start_q;
    assign fsm2.next_instr = nextInstr_q;
    assign busy_o          = busy_q;
    assign err_timeout_o   = errTimeout_q;
    assign err_illegal_o   = errIllegal_q;
    assign fire_count_o    = fireCount_q;

endmodule

// File: tb/tb_cfdf_fire_scheduler.sv
// Directed bench for the CFDF fire scheduler: plays the nested FSM by hand
// and checks start pulses, rate stalls, RST timing, errors and the counter.
module tb_cfdf_fire_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [9:0]  popData;
    logic [9:0]  popCmd;
    logic [9:0]  freeOut;
    logic        busy;
    logic        errTimeout;
    logic        errIllegal;
    logic [15:0] fireCount;

    int checks   = 0;
    int failures = 0;
    int starts;

    cfdf_fire_scheduler_if fsm2If();

    cfdf_fire_scheduler dut (
        .clk                   (clk),
        .rst                   (rst),
        .run_i                 (run),
        .pop_in_fifo_data_i    (popData),
        .pop_in_fifo_command_i (popCmd),
        .free_out_fifo_i       (freeOut),
        .fsm2                  (fsm2If),
        .busy_o                (busy),
        .err_timeout_o         (errTimeout),
        .err_illegal_o         (errIllegal),
        .fire_count_o          (fireCount)
    );

    // 100 MHz clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic runV, input logic [9:0] cmdV, input logic [9:0] dataV,
                                 input logic [9:0] freeV, input logic [7:0] instrV, input logic [4:0] argV);
        run           = runV;
        popCmd        = cmdV;
        popData       = dataV;
        freeOut       = freeV;
        fsm2If.instr  = instrV;
        fsm2If.arg2   = argV;
    endtask

    task automatic waitForStart(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fsm2If.start_fsm2) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulseDone(input int delay);
        repeat (delay) @(negedge clk);
        fsm2If.done_fsm2 = 1'b1;
        @(negedge clk);
        fsm2If.done_fsm2 = 1'b0;
    endtask

    task automatic idleCycles(input int n, output int seenStarts);
        seenStarts = 0;
        repeat (n) begin
            @(negedge clk);
            if (fsm2If.start_fsm2) seenStarts++;
        end
    endtask

    task automatic setupPhase(input string tag);
        waitForStart({tag, "_setup_start"});
        checkOutput({tag, "_setup_mode"}, 32'(fsm2If.next_instr), 32'd0);
        popCmd = 10'd0;
        @(negedge clk);
        checkOutput({tag, "_setup_pulse_width"}, 32'(fsm2If.start_fsm2), 32'd0);
        pulseDone(1);
    endtask

    task automatic instrPhase(input string tag);
        waitForStart({tag, "_instr_start"});
        checkOutput({tag, "_instr_mode"}, 32'(fsm2If.next_instr), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_instr_pulse_width"}, 32'(fsm2If.start_fsm2), 32'd0);
        pulseDone(1);
    endtask

    // Directed scenario sequence
    initial begin
        rst              = 1'b0;
        fsm2If.done_fsm2 = 1'b0;
        applyStimulus(1'b0, 10'd0, 10'd0, 10'd0, 8'd0, 5'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_start", 32'(fsm2If.start_fsm2), 32'd0);
        checkOutput("reset_mode", 32'(fsm2If.next_instr), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err_timeout", 32'(errTimeout), 32'd0);
        checkOutput("reset_err_illegal", 32'(errIllegal), 32'd0);
        checkOutput("reset_fire_count", 32'(fireCount), 32'd0);
        rst = 1'b1;

        $display("[TB] STP arg2=3 full firing");
        applyStimulus(1'b1, 10'd1, 10'd4, 10'd8, 8'd0, 5'd3);
        setupPhase("stp");
        instrPhase("stp");
        idleCycles(5, starts);
        checkOutput("stp_no_extra_start", 32'(starts), 32'd0);
        checkOutput("stp_fire_count", 32'(fireCount), 32'd1);
        checkOutput("stp_busy_in_check_cmd", 32'(busy), 32'd1);

        $display("[TB] EVB arg2=5 rate stall, run ignored while stalled");
        applyStimulus(1'b1, 10'd1, 10'd4, 10'd8, 8'd2, 5'd5);
        setupPhase("evb");
        run = 1'b0;
        idleCycles(6, starts);
        checkOutput("evb_stall_no_start", 32'(starts), 32'd0);
        checkOutput("evb_stall_busy", 32'(busy), 32'd1);
        popData = 10'd5;
        @(negedge clk);
        checkOutput("evb_release_start", 32'(fsm2If.start_fsm2), 32'd1);
        checkOutput("evb_release_mode", 32'(fsm2If.next_instr), 32'd1);
        @(negedge clk);
        pulseDone(1);
        checkOutput("evb_fire_count", 32'(fireCount), 32'd2);
        checkOutput("evb_idle_after_run_low", 32'(busy), 32'd0);

        $display("[TB] RST instruction completes without done");
        applyStimulus(1'b1, 10'd1, 10'd0, 10'd0, 8'd3, 5'd0);
        setupPhase("rst");
        waitForStart("rst_instr_start");
        @(negedge clk);
        checkOutput("rst_wait_cycle1", 32'(fireCount), 32'd2);
        fsm2If.done_fsm2 = 1'b1;
        @(negedge clk);
        fsm2If.done_fsm2 = 1'b0;
        checkOutput("rst_wait_cycle2", 32'(fireCount), 32'd2);
        @(negedge clk);
        checkOutput("rst_fire_count", 32'(fireCount), 32'd3);
        checkOutput("rst_busy_in_check_cmd", 32'(busy), 32'd1);

        $display("[TB] illegal instruction 7");
        checkOutput("illegal_clear_before", 32'(errIllegal), 32'd0);
        applyStimulus(1'b1, 10'd1, 10'd8, 10'd8, 8'd7, 5'd0);
        setupPhase("illegal");
        idleCycles(4, starts);
        checkOutput("illegal_no_start", 32'(starts), 32'd0);
        checkOutput("illegal_flag", 32'(errIllegal), 32'd1);
        checkOutput("illegal_fire_count", 32'(fireCount), 32'd3);

        $display("[TB] STP arg2=31 needs 32 data tokens");
        applyStimulus(1'b1, 10'd1, 10'd31, 10'd1, 8'd0, 5'd31);
        setupPhase("stp31");
        idleCycles(4, starts);
        checkOutput("stp31_stall_at_31", 32'(starts), 32'd0);
        popData = 10'd32;
        instrPhase("stp31");
        checkOutput("stp31_fire_count", 32'(fireCount), 32'd4);

        $display("[TB] EVB arg2=0 fires with empty FIFOs");
        applyStimulus(1'b1, 10'd1, 10'd0, 10'd0, 8'd2, 5'd0);
        setupPhase("evb0");
        instrPhase("evb0");
        checkOutput("evb0_fire_count", 32'(fireCount), 32'd5);

        $display("[TB] run dropped during WAIT_INSTR");
        applyStimulus(1'b1, 10'd1, 10'd1, 10'd1, 8'd1, 5'd0);
        setupPhase("drop");
        waitForStart("drop_instr_start");
        run = 1'b0;
        @(negedge clk);
        pulseDone(1);
        checkOutput("drop_fire_count", 32'(fireCount), 32'd6);
        checkOutput("drop_busy", 32'(busy), 32'd0);
        idleCycles(3, starts);
        checkOutput("drop_stays_idle", 32'(starts), 32'd0);

        $display("[TB] fire_count wrap");
        force dut.fireCount_q = 16'hFFFF;
        @(negedge clk);
        release dut.fireCount_q;
        @(negedge clk);
        checkOutput("wrap_preload", 32'(fireCount), 32'h0000FFFF);
        applyStimulus(1'b1, 10'd1, 10'd1, 10'd1, 8'd1, 5'd0);
        setupPhase("wrap");
        instrPhase("wrap");
        checkOutput("wrap_fire_count", 32'(fireCount), 32'd0);

        $display("[TB] done on the watchdog expiry edge");
        applyStimulus(1'b1, 10'd1, 10'd1, 10'd1, 8'd1, 5'd0);
        waitForStart("edge_setup_start");
        popCmd = 10'd0;
        repeat (4096) @(negedge clk);
        fsm2If.done_fsm2 = 1'b1;
        @(negedge clk);
        fsm2If.done_fsm2 = 1'b0;
        checkOutput("edge_done_wins", 32'(errTimeout), 32'd0);
        instrPhase("edge");
        checkOutput("edge_fire_count", 32'(fireCount), 32'd1);

        $display("[TB] watchdog timeout and reset recovery");
        applyStimulus(1'b1, 10'd1, 10'd1, 10'd1, 8'd1, 5'd0);
        waitForStart("timeout_setup_start");
        popCmd = 10'd0;
        repeat (4096) @(negedge clk);
        checkOutput("timeout_not_yet", 32'(errTimeout), 32'd0);
        @(negedge clk);
        checkOutput("timeout_flag", 32'(errTimeout), 32'd1);
        checkOutput("timeout_busy", 32'(busy), 32'd1);
        idleCycles(10, starts);
        checkOutput("timeout_no_start", 32'(starts), 32'd0);
        checkOutput("timeout_sticky", 32'(errTimeout), 32'd1);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rerst_start", 32'(fsm2If.start_fsm2), 32'd0);
        checkOutput("rerst_mode", 32'(fsm2If.next_instr), 32'd0);
        checkOutput("rerst_busy", 32'(busy), 32'd0);
        checkOutput("rerst_err_timeout", 32'(errTimeout), 32'd0);
        checkOutput("rerst_err_illegal", 32'(errIllegal), 32'd0);
        checkOutput("rerst_fire_count", 32'(fireCount), 32'd0);
        idleCycles(3, starts);
        checkOutput("rerst_stays_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
